// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, bus widths and arbiter state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vga_pkg;

  localparam int FB_W       = 160;  // logical pixels per row
  localparam int FB_H       = 120;  // logical rows
  localparam int SCALE_LOG2 = 2;    // log2 of screen pixels per logical pixel, per axis
  localparam int ADDR_W     = 15;   // frame RAM address width
  localparam int COLOR_W    = 8;    // pixel colour width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Linear frame-buffer address from logical (x, y): y*FB_W + x, wrapping modulo 2^ADDR_W.
// Latency: purely combinational.
// Backpressure: none.
// Ports: x_i/y_i logical coordinates, addr_o linear RAM address.
module fb_addr_gen
  import vga_pkg::*;
#(
  parameter int FB_W = vga_pkg::FB_W
) (
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic [ADDR_W-1:0] addr_o
);

  // All operands sized to ADDR_W so the product and sum wrap at 2^ADDR_W.
  assign addr_o = ADDR_W'(y_i) * ADDR_W'(FB_W) + ADDR_W'(x_i);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame RAM arbiter: display fetch > buffer clear > pixel write.
// Latency: fetch data reaches pix_color 2 cycles after the fetch slot; writes issue in the handshake cycle.
// Backpressure: wr_ready low in fetch slots and while a clear is running.
// Ports: video_on/pixel_x/pixel_y display timing; wr_* write request; clear_* fill control;
//        mem_* frame RAM command and read data; pix_color/pix_valid display colour out.
module fb_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W       = vga_pkg::FB_W,
  parameter int FB_H       = vga_pkg::FB_H,
  parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2
) (
  input  logic               clk_25MHz,
  input  logic               rst,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               wr_valid,
  input  logic [7:0]         wr_x,
  input  logic [6:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                done_q, done_d;
  logic [1:0]          vid_q;      // video_on delay line, [1] is two cycles old
  logic                fetch_q;    // a fetch was issued last cycle
  logic [COLOR_W-1:0]  pix_q;

  logic                fetch_slot;
  logic                wr_in_range;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [ADDR_W-1:0]   wr_addr;

  // One RAM slot out of every 2^SCALE_LOG2 screen pixels feeds the display.
  assign fetch_slot = video_on && (pixel_x[SCALE_LOG2-1:0] == '0);

  fb_addr_gen #(.FB_W(FB_W)) u_fetch_addr (
    .x_i    (pixel_x >> SCALE_LOG2),
    .y_i    (pixel_y >> SCALE_LOG2),
    .addr_o (fetch_addr)
  );

  fb_addr_gen #(.FB_W(FB_W)) u_wr_addr (
    .x_i    ({2'b00, wr_x}),
    .y_i    ({3'b000, wr_y}),
    .addr_o (wr_addr)
  );

  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign wr_ready    = (state_q == ST_IDLE) && !fetch_slot;
  assign clear_busy  = (state_q == ST_CLEAR);
  assign clear_done  = done_q;
  assign pix_valid   = vid_q[1];
  assign pix_color   = vid_q[1] ? pix_q : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (fetch_slot) begin
      mem_addr = fetch_addr;
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = color_q;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (wr_valid && wr_in_range) begin
      // wr_ready is implied here: IDLE and not a fetch slot.
      // Out-of-range requests still handshake but never reach the RAM.
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end

    // Start is sampled only in IDLE, so a restart mid-fill is impossible.
    if (state_q == ST_IDLE && clear_start) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
      color_d = clear_color;
    end
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
      vid_q   <= '0;
      fetch_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
      vid_q   <= {vid_q[0], video_on};
      fetch_q <= fetch_slot;
      // RAM data for last cycle's fetch is on mem_rdata now.
      if (fetch_q) pix_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  logic        clk_25MHz = 1'b0;
  logic        rst = 1'b1;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_color = '0;
  logic        clear_busy;
  logic        clear_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_color;
  logic        pix_valid;

  int vectors = 0;
  int errs = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  fb_arbiter dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .wr_valid    (wr_valid),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pix_color   (pix_color),
    .pix_valid   (pix_valid)
  );

  // Synchronous single-port RAM model with a bench backdoor write port.
  logic [7:0]  ram [0:32767];
  logic        bd_we = 1'b0;
  logic [14:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge clk_25MHz) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Clear-activity monitor, sampled mid-cycle.
  logic mon_clr = 1'b1;
  logic [7:0] mon_color = '0;
  int busy_cnt, we_cnt, done_cnt, seq_err, bad_color, we_fetch, rdy_busy;
  int mon_cyc, mon_next, last_cyc, done_cyc;

  always @(negedge clk_25MHz) begin
    if (mon_clr) begin
      busy_cnt <= 0; we_cnt <= 0; done_cnt <= 0; seq_err <= 0; bad_color <= 0;
      we_fetch <= 0; rdy_busy <= 0; mon_cyc <= 0; mon_next <= 0;
      last_cyc <= -10; done_cyc <= -20;
    end else begin
      mon_cyc <= mon_cyc + 1;
      if (clear_busy) busy_cnt <= busy_cnt + 1;
      if (mem_we && clear_busy) begin
        we_cnt   <= we_cnt + 1;
        mon_next <= mon_next + 1;
        if (int'(mem_addr) != mon_next) seq_err <= seq_err + 1;
        if (mem_wdata != mon_color) bad_color <= bad_color + 1;
        if (mem_addr == 15'd19199) last_cyc <= mon_cyc;
      end
      if (clear_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= mon_cyc;
      end
      if (mem_we && video_on && pixel_x[1:0] == 2'b00) we_fetch <= we_fetch + 1;
      if (wr_ready && clear_busy) rdy_busy <= rdy_busy + 1;
    end
  end

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen;
    logic [7:0] exp_pix;

    // ---- reset, RAM preload through the backdoor ----
    tick(); bd_we = 1'b1; bd_addr = 15'd0;   bd_data = 8'h11;
    tick(); bd_addr = 15'd1;   bd_data = 8'h22;
    tick(); bd_addr = 15'd160; bd_data = 8'h99;
    tick(); bd_we = 1'b0;
    #1;
    chk("rst clear_busy", 32'(clear_busy), 32'd0);
    chk("rst clear_done", 32'(clear_done), 32'd0);
    chk("rst pix_valid",  32'(pix_valid),  32'd0);
    chk("rst pix_color",  32'(pix_color),  32'd0);
    chk("rst mem_we",     32'(mem_we),     32'd0);
    chk("rst mem_addr",   32'(mem_addr),   32'd0);
    chk("rst wr_ready",   32'(wr_ready),   32'd1);
    tick(); rst = 1'b0;
    tick();

    // ---- display fetch: pixel_x 0..9 on row 0 ----
    for (int k = 0; k < 10; k++) begin
      tick();
      video_on = 1'b1; pixel_y = 10'd0; pixel_x = 10'(k);
      #1;
      chk($sformatf("fetch mem_addr x=%0d", k), 32'(mem_addr), (k % 4 == 0) ? 32'(k / 4) : 32'd0);
      chk($sformatf("fetch mem_we x=%0d", k), 32'(mem_we), 32'd0);
      chk($sformatf("fetch wr_ready x=%0d", k), 32'(wr_ready), (k % 4 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("pix_valid x=%0d", k), 32'(pix_valid), (k >= 2) ? 32'd1 : 32'd0);
      exp_pix = (k < 2) ? 8'h00 : (k < 6) ? 8'h11 : 8'h22;
      chk($sformatf("pix_color x=%0d", k), 32'(pix_color), 32'(exp_pix));
    end
    for (int k = 10; k < 13; k++) begin
      tick();
      video_on = 1'b0; pixel_x = 10'(k);
      #1;
      if (k == 11) chk("pix_valid tail", 32'(pix_valid), 32'd1);
      if (k == 12) begin
        chk("pix_valid off", 32'(pix_valid), 32'd0);
        chk("pix_color off", 32'(pix_color), 32'd0);
      end
    end

    // ---- write held across a fetch slot ----
    tick();
    video_on = 1'b1; pixel_y = 10'd8; pixel_x = 10'd4;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 8'hAB;
    #1;
    chk("wr fetch wr_ready", 32'(wr_ready), 32'd0);
    chk("wr fetch mem_we",   32'(mem_we),   32'd0);
    chk("wr fetch mem_addr", 32'(mem_addr), 32'd321);
    tick();
    pixel_x = 10'd5;
    #1;
    chk("wr issue wr_ready",  32'(wr_ready),  32'd1);
    chk("wr issue mem_we",    32'(mem_we),    32'd1);
    chk("wr issue mem_addr",  32'(mem_addr),  32'd485);
    chk("wr issue mem_wdata", 32'(mem_wdata), 32'hAB);
    tick();
    wr_valid = 1'b0; video_on = 1'b0;
    #1;
    chk("ram[485] written", 32'(ram[485]), 32'hAB);

    // ---- out-of-range write is accepted and dropped ----
    tick();
    wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_data = 8'h77;
    #1;
    chk("oor wr_ready", 32'(wr_ready), 32'd1);
    chk("oor mem_we",   32'(mem_we),   32'd0);
    chk("oor mem_addr", 32'(mem_addr), 32'd0);
    tick();
    wr_x = 8'd0; wr_y = 7'd120;
    #1;
    chk("oor y mem_we", 32'(mem_we), 32'd0);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("ram[160] kept", 32'(ram[160]), 32'h99);

    // ---- clear with video off, handshake in the start cycle ----
    mon_color = 8'h3C;
    tick();
    mon_clr = 1'b0;
    clear_start = 1'b1; clear_color = 8'h3C;
    wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd0; wr_data = 8'h5A;
    #1;
    chk("start wr_ready",  32'(wr_ready),  32'd1);
    chk("start mem_we",    32'(mem_we),    32'd1);
    chk("start mem_addr",  32'(mem_addr),  32'd1);
    chk("start mem_wdata", 32'(mem_wdata), 32'h5A);
    seen = 1'b0;
    for (int i = 0; i < 30000 && !seen; i++) begin
      tick();
      clear_start = 1'b0; wr_valid = 1'b0;
      #1;
      if (clear_done) seen = 1'b1;
    end
    chk("clr1 done seen", 32'(seen), 32'd1);
    tick(); tick();
    chk("clr1 busy cycles",  32'(busy_cnt),  32'd19200);
    chk("clr1 writes",       32'(we_cnt),    32'd19200);
    chk("clr1 seq errors",   32'(seq_err),   32'd0);
    chk("clr1 bad colour",   32'(bad_color), 32'd0);
    chk("clr1 done pulses",  32'(done_cnt),  32'd1);
    chk("clr1 done timing",  32'(done_cyc),  32'(last_cyc + 1));
    chk("clr1 ready busy",   32'(rdy_busy),  32'd0);
    chk("clr1 busy after",   32'(clear_busy), 32'd0);
    chk("clr1 ram[0]",       32'(ram[0]),     32'h3C);
    chk("clr1 ram[485]",     32'(ram[485]),   32'h3C);
    chk("clr1 ram[19199]",   32'(ram[19199]), 32'h3C);

    // ---- clear with video running, second start ignored ----
    mon_clr = 1'b1; mon_color = 8'hC3;
    tick();
    mon_clr = 1'b0;
    video_on = 1'b1; pixel_y = 10'd0; pixel_x = 10'd3;
    clear_start = 1'b1; clear_color = 8'hC3;
    seen = 1'b0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      tick();
      pixel_x = (pixel_x == 10'd639) ? 10'd0 : pixel_x + 10'd1;
      clear_start = (i == 5000);
      clear_color = (i == 5000) ? 8'hFF : 8'hC3;
      #1;
      if (clear_done) seen = 1'b1;
    end
    chk("clr2 done seen", 32'(seen), 32'd1);
    tick();
    video_on = 1'b0; clear_start = 1'b0;
    tick();
    chk("clr2 busy cycles",  32'(busy_cnt),  32'd25600);
    chk("clr2 writes",       32'(we_cnt),    32'd19200);
    chk("clr2 fetch writes", 32'(we_fetch),  32'd0);
    chk("clr2 seq errors",   32'(seq_err),   32'd0);
    chk("clr2 bad colour",   32'(bad_color), 32'd0);
    chk("clr2 done pulses",  32'(done_cnt),  32'd1);
    chk("clr2 ram[19199]",   32'(ram[19199]), 32'hC3);

    // ---- reset mid-clear at counter 1000 ----
    mon_clr = 1'b1; mon_color = 8'h55;
    tick();
    mon_clr = 1'b0;
    clear_start = 1'b1; clear_color = 8'h55;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      clear_start = 1'b0;
      #1;
      if (mem_we && mem_addr == 15'd1000) seen = 1'b1;
    end
    chk("abort reached 1000", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort mem_we",     32'(mem_we),     32'd0);
    chk("abort mem_addr",   32'(mem_addr),   32'd0);
    chk("abort clear_busy", 32'(clear_busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("abort done pulses", 32'(done_cnt),   32'd0);
    chk("abort writes",      32'(we_cnt),     32'd1000);
    chk("abort wr_ready",    32'(wr_ready),   32'd1);
    chk("abort ram[999]",    32'(ram[999]),   32'h55);
    chk("abort ram[1000]",   32'(ram[1000]),  32'hC3);
    chk("abort ram[19199]",  32'(ram[19199]), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_W, default 160, frame-buffer width in logical pixels.
REQ-002 Parameter FB_H, default 120, frame-buffer height in logical pixels.
REQ-003 Parameter SCALE_LOG2, default 2, log2 of screen pixels per logical pixel on each axis.
REQ-004 clk_25MHz  input  1  pixel clock, single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 video_on, pixel_x[9:0], pixel_y[9:0]  input  1/10/10  display timing position, valid in the same cycle.
REQ-007 wr_valid, wr_x[7:0], wr_y[6:0], wr_data[7:0]  input  1/8/7/8  logical-pixel write request.
REQ-008 wr_ready  output  1  write accepted this cycle when wr_valid is also high.
REQ-009 clear_start, clear_color[7:0]  input  1/8  request a full-buffer fill with clear_color.
REQ-010 clear_busy, clear_done  output  1/1  fill in progress; one-cycle pulse on fill completion.
REQ-011 mem_addr[14:0], mem_we, mem_wdata[7:0]  output  15/1/8  single-port frame RAM command.
REQ-012 mem_rdata[7:0]  input  8  RAM read data, valid exactly one cycle after the read address.
REQ-013 pix_color[7:0], pix_valid  output  8/1  colour for the display pipeline.

Function
REQ-014 Fetch slot = video_on && pixel_x[SCALE_LOG2-1:0]==0; fetch slots always own the RAM, with mem_we=0.
REQ-015 Fetch address = (pixel_y>>SCALE_LOG2)*FB_W + (pixel_x>>SCALE_LOG2), computed modulo 2^15 with no overflow at 119*160+159=19199.
REQ-016 A fetch issued in cycle T is captured from mem_rdata at the end of T+1; pix_color holds it from T+2 until the next capture.
REQ-017 pix_valid = video_on delayed by exactly 2 cycles; pix_color = 0 whenever pix_valid = 0.
REQ-018 States: IDLE and CLEAR.
REQ-019 wr_ready = (state==IDLE) && !fetch slot; it is combinational and depends on no other input.
REQ-020 On wr_valid && wr_ready, the write is issued in the same cycle: mem_we=1, mem_addr=wr_y*FB_W+wr_x, mem_wdata=wr_data.
REQ-021 A handshake with wr_x>=FB_W or wr_y>=FB_H is accepted and discarded, with mem_we=0.
REQ-022 IDLE->CLEAR on clear_start: clear_color is latched, the clear counter is set to 0, and the handshake in that cycle, if any, still completes.
REQ-023 CLEAR: each non-fetch cycle writes the latched colour at the counter address, then increments the counter; fetch cycles stall the counter.
REQ-024 CLEAR->IDLE after the write to address FB_W*FB_H-1; clear_done pulses high in the cycle after that write.
REQ-025 clear_busy = (state==CLEAR); clear_start during CLEAR is ignored, with no restart and no colour change.
REQ-026 Idle slots (no fetch, no write, no clear) drive mem_we=0 and mem_addr=0.
REQ-027 Fetch has strict priority; wr_valid held high during active video is served in the 3 non-fetch cycles of each 4.

Reset
REQ-028 On rst: state=IDLE, clear counter=0, latched colour=0, pix_color=0, pix_valid=0, the delay pipeline is cleared, clear_done=0, clear_busy=0, mem_we=0, mem_addr=0.
REQ-029 Reset asserted mid-CLEAR aborts the fill immediately with no further writes and no clear_done pulse.
REQ-030 The first fetch after reset release follows REQ-016 with no extra latency.

Structure
REQ-031 FB_W, FB_H, SCALE_LOG2, the address width (15), the colour width (8) and the state encoding belong in shared package vga_pkg.
REQ-032 The x/y-to-linear-address multiply-add is one sub-module, fb_addr_gen, instantiated for both the fetch path and the write path.

Verification
REQ-033 After reset, drive video_on=1, pixel_x=0..7, pixel_y=0 with RAM preloaded addr0=0x11 and addr1=0x22 -> fetch at pixel_x 0 and 4 only; pix_color=0x11 for 4 cycles starting 2 cycles after pixel_x=0, then 0x22.
REQ-034 Hold wr_valid=1, wr_x=5, wr_y=3, wr_data=0xAB across a fetch slot -> wr_ready=0 in the fetch cycle, and the write issues in the next cycle at mem_addr=485.
REQ-035 Write with wr_x=160, wr_y=0 -> wr_ready=1 and a handshake occurs with mem_we=0; the RAM is unchanged.
REQ-036 With video_on=0, pulse clear_start with clear_color=0x3C -> clear_busy high for 19200 cycles, every address is written with 0x3C, clear_done pulses once, and wr_ready=0 throughout.
REQ-037 With video_on=1 during a clear -> the clear takes 25600 cycles with no writes in fetch slots; a second clear_start mid-fill has no effect.
REQ-038 Assert rst at counter=1000 during a clear -> mem_we=0 immediately, state=IDLE, no clear_done pulse, and addresses >=1000 keep their prior contents.
